branch_resolve_queue: RTL

In-order queue between fetch-time branch prediction and execute-time branch resolution. Each predicted branch is recorded with its predicted direction and alternate-path PC. When the oldest branch resolves, the queue drives the direction predictor's training inputs (`branch_op`/`taken`). On a direction mismatch it raises a one-cycle mispredict/redirect and flushes every younger entry. The block sits directly downstream of `Branch_predictor`'s `Predict` output and upstream of its update inputs.

---
 rtl/bp_pkg.sv | 18 +
 rtl/brq_fifo_mem.sv | 26 ++
 rtl/branch_resolve_queue.sv | 130 +++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared types and default sizing for the branch resolve queue.
// The optional BRQ_STATS_EN build macro adds resolve/mispredict counters to the top level.
package bp_pkg;

   localparam int BP_DEPTH = 4;
   localparam int BP_PC_W  = 32;

   typedef struct packed {
      logic               pred;
      logic [BP_PC_W-1:0] alt_pc;
   } bp_entry_t;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } brq_state_t;

endpackage

// File: rtl/brq_fifo_mem.sv
// Entry storage for the branch resolve queue: one write port and one asynchronous read port.
// Pointer, count and flush control live in the top level.
module brq_fifo_mem
   import bp_pkg::*;
#(
   parameter int  DEPTH   = BP_DEPTH,
   parameter type entry_t = bp_entry_t
) (
   input  logic                     clock,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  entry_t                   wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output entry_t                   rdata
);

   entry_t mem [DEPTH];

   // NOTE: storage has no reset; count and pointers decide validity, so stale entries are never observed.
   always_ff @(posedge clock) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order queue between branch prediction and execute-time resolution; trains the predictor and flushes on mispredict.
// Define BRQ_STATS_EN to add the stat_resolved / stat_mispred saturating counters.
module branch_resolve_queue
   import bp_pkg::*;
#(
   parameter int DEPTH = BP_DEPTH,
   parameter int PC_W  = BP_PC_W
) (
   input  logic            clock,
   input  logic            rst,
   input  logic            push,
   input  logic            push_pred,
   input  logic [PC_W-1:0] push_alt_pc,
   output logic            full,
   output logic            empty,
   input  logic            resolve_valid,
   input  logic            resolve_taken,
   output logic            upd_valid,
   output logic            upd_taken,
   output logic            mispredict,
   output logic [PC_W-1:0] redirect_pc,
`ifdef BRQ_STATS_EN
   output logic [31:0]     stat_resolved,
   output logic [31:0]     stat_mispred,
`endif
   output logic            underflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic            pred;
      logic [PC_W-1:0] alt_pc;
   } entry_t;

   logic [PTR_W-1:0] head_q, tail_q;
   logic [CNT_W-1:0] count_q;
   brq_state_t       state_q, state_d;
   entry_t           head_entry, push_entry;
   logic             pop, mis, push_ok, resolve_empty;

   assign full       = (count_q == CNT_W'(DEPTH));
   assign empty      = (count_q == '0);
   assign push_entry = '{pred: push_pred, alt_pc: push_alt_pc};

   brq_fifo_mem #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_mem (
      .clock (clock),
      .we    (push_ok),
      .waddr (tail_q),
      .wdata (push_entry),
      .raddr (head_q),
      .rdata (head_entry)
   );

   always_ff @(posedge clock) begin
      if (rst) state_q <= RUN;
      else     state_q <= state_d;
   end

   // NOTE: every signal driven here gets a default first so no latch is inferred.
   always_comb begin
      state_d       = state_q;
      pop           = 1'b0;
      mis           = 1'b0;
      push_ok       = 1'b0;
      resolve_empty = 1'b0;
      case (state_q)
         RUN: begin
            pop           = resolve_valid && !empty;
            mis           = pop && (resolve_taken != head_entry.pred);
            // A push beside a mispredict is on the wrong path and is dropped.
            push_ok       = push && (!full || pop) && !mis;
            resolve_empty = resolve_valid && empty;
            if (mis) state_d = FLUSH;
         end
         FLUSH:   state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clock) begin
      if (rst) begin
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         upd_valid   <= 1'b0;
         upd_taken   <= 1'b0;
         mispredict  <= 1'b0;
         redirect_pc <= '0;
         underflow   <= 1'b0;
      end else begin
         upd_valid  <= pop;
         upd_taken  <= pop & resolve_taken;
         mispredict <= mis;
         if (mis)           redirect_pc <= head_entry.alt_pc;
         if (resolve_empty) underflow   <= 1'b1;
         if (mis) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
         end else begin
            if (pop)     head_q <= head_q + PTR_W'(1);
            if (push_ok) tail_q <= tail_q + PTR_W'(1);
            case ({push_ok, pop})
               2'b10:   count_q <= count_q + CNT_W'(1);
               2'b01:   count_q <= count_q - CNT_W'(1);
               default: count_q <= count_q;
            endcase
         end
      end
   end

`ifdef BRQ_STATS_EN
   always_ff @(posedge clock) begin
      if (rst) begin
         stat_resolved <= '0;
         stat_mispred  <= '0;
      end else begin
         if (pop && stat_resolved != 32'hFFFF_FFFF) stat_resolved <= stat_resolved + 32'd1;
         if (mis && stat_mispred  != 32'hFFFF_FFFF) stat_mispred  <= stat_mispred + 32'd1;
      end
   end
`endif

endmodule
